adc_channel_aggregator: RTL and testbench

//  Parametrised successor of the fixed 13-channel voltmeter datapath. Collects tagged ADC

---
 rtl/adc_channel_aggregator_pkg.sv | 20 ++
 rtl/adc_channel_aggregator_streamer.sv | 109 ++++++++++
 rtl/adc_channel_aggregator.sv | 96 +++++++++
 tb/tb_adc_channel_aggregator.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_channel_aggregator_pkg.sv
// Shared constants and types for the ADC channel aggregator and its snapshot frame streamer.
package adc_channel_aggregator_pkg;

  localparam logic [7:0] AGG_FRAME_HDR = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CH_ID,
    ST_DAT_H,
    ST_DAT_L,
    ST_CSUM
  } frame_state_e;

  // Channel-index width; a single channel still needs one tag bit.
  function automatic int ch_idx_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/adc_channel_aggregator_streamer.sv
// Snapshot frame streamer: header, {channel id, 16-bit big-endian average}*, XOR checksum,
// sent over a valid/ready byte interface with registered outputs.
module adc_channel_aggregator_streamer
  import adc_channel_aggregator_pkg::*;
#(
  parameter int  N_CH = 13,
  parameter int  DW   = 12,
  localparam int CHW  = ch_idx_width(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH*DW-1:0] avg_bus,
  input  logic [N_CH-1:0]    ch_enable,
  input  logic               dump_req,
  input  logic               m_ready,
  output logic               busy,
  output logic               m_valid,
  output logic [7:0]         m_data
);

  frame_state_e       state_q;
  logic [N_CH*DW-1:0] snap_avg_q;
  logic [N_CH-1:0]    rem_q;
  logic [CHW-1:0]     cur_q;
  logic [7:0]         csum_q;
  logic [7:0]         data_q;
  logic               valid_q;
  logic               busy_q;

  logic               fire;
  logic               nxt_found;
  logic [CHW-1:0]     nxt_idx;
  logic [15:0]        cur_avg;

  assign fire    = valid_q && m_ready;
  assign cur_avg = 16'(snap_avg_q[int'(cur_q)*DW +: DW]);

  // Lowest channel still pending in the snapshot mask.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rem_q[i]) begin
        nxt_found = 1'b1;
        nxt_idx   = CHW'(i);
      end
    end
  end

  // NOTE: flops use non-blocking (<=) so each update sees only pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      snap_avg_q <= '0;
      rem_q      <= '0;
      cur_q      <= '0;
      csum_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (dump_req) begin
          snap_avg_q <= avg_bus;
          rem_q      <= ch_enable;
          csum_q     <= '0;
          data_q     <= AGG_FRAME_HDR;
          valid_q    <= 1'b1;
          busy_q     <= 1'b1;
          state_q    <= ST_HDR;
        end
        ST_HDR, ST_DAT_L: if (fire) begin
          csum_q <= csum_q ^ data_q;
          if (nxt_found) begin
            data_q         <= 8'(nxt_idx);
            cur_q          <= nxt_idx;
            rem_q[nxt_idx] <= 1'b0;
            state_q        <= ST_CH_ID;
          end else begin
            data_q  <= csum_q ^ data_q;
            state_q <= ST_CSUM;
          end
        end
        ST_CH_ID: if (fire) begin
          csum_q  <= csum_q ^ data_q;
          data_q  <= cur_avg[15:8];
          state_q <= ST_DAT_H;
        end
        ST_DAT_H: if (fire) begin
          csum_q  <= csum_q ^ data_q;
          data_q  <= cur_avg[7:0];
          state_q <= ST_DAT_L;
        end
        ST_CSUM: if (fire) begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign m_valid = valid_q;
  assign m_data  = data_q;

endmodule

// File: rtl/adc_channel_aggregator.sv
// Per-channel box-car averager over a shared tagged sample stream, plus a snapshot frame
// streamer that serialises the enabled channel averages as a checksummed byte frame.
module adc_channel_aggregator
  import adc_channel_aggregator_pkg::*;
#(
  parameter int  N_CH     = 13,
  parameter int  DW       = 12,
  parameter int  AVG_LOG2 = 4,
  localparam int CHW      = ch_idx_width(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  input  logic [CHW-1:0]     s_ch,
  input  logic [DW-1:0]      s_data,
  input  logic [N_CH-1:0]    ch_enable,
  output logic [N_CH*DW-1:0] avg_bus,
  output logic [N_CH-1:0]    avg_update,
  output logic               err_ch,
  input  logic               dump_req,
  output logic               busy,
  output logic               m_valid,
  output logic [7:0]         m_data,
  input  logic               m_ready
);

  localparam int              CNTW     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int              AW       = DW + AVG_LOG2;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'((1 << AVG_LOG2) - 1);

  logic err_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [AW-1:0]   acc_q;
    logic [CNTW-1:0] cnt_q;
    logic [DW-1:0]   avg_q;
    logic            upd_q;
    logic            hit;
    logic [AW-1:0]   sum;

    assign hit = s_valid && (s_ch == CHW'(k));
    assign sum = acc_q + AW'(s_data);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        // NOTE: these per-channel arrays are plain flops, not RAM, so resetting them is fine.
        acc_q <= '0;
        cnt_q <= '0;
        avg_q <= '0;
        upd_q <= 1'b0;
      end else begin
        upd_q <= 1'b0;
        if (!ch_enable[k]) begin
          acc_q <= '0;
          cnt_q <= '0;
        end else if (hit) begin
          if (cnt_q == CNT_LAST) begin
            avg_q <= DW'(sum >> AVG_LOG2);
            acc_q <= '0;
            cnt_q <= '0;
            upd_q <= 1'b1;
          end else begin
            acc_q <= sum;
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end
    end

    assign avg_bus[k*DW +: DW] = avg_q;
    assign avg_update[k]       = upd_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= s_valid && (int'(s_ch) >= N_CH);
  end

  assign err_ch = err_q;

  adc_channel_aggregator_streamer #(
    .N_CH (N_CH),
    .DW   (DW)
  ) u_streamer (
    .clk       (clk),
    .rst       (rst),
    .avg_bus   (avg_bus),
    .ch_enable (ch_enable),
    .dump_req  (dump_req),
    .m_ready   (m_ready),
    .busy      (busy),
    .m_valid   (m_valid),
    .m_data    (m_data)
  );

endmodule

// File: tb/tb_adc_channel_aggregator.sv
// Self-checking bench for adc_channel_aggregator: sample-list averaging model and a
// frame builder derived from the byte-level frame rules.
module tb_adc_channel_aggregator;

  localparam int N_CH     = 13;
  localparam int DW       = 12;
  localparam int AVG_LOG2 = 2;
  localparam int CHW      = $clog2(N_CH);
  localparam int NAVG     = 1 << AVG_LOG2;

  logic               clk       = 1'b0;
  logic               rst       = 1'b0;
  logic               s_valid   = 1'b0;
  logic [CHW-1:0]     s_ch      = '0;
  logic [DW-1:0]      s_data    = '0;
  logic [N_CH-1:0]    ch_enable = '0;
  logic [N_CH*DW-1:0] avg_bus;
  logic [N_CH-1:0]    avg_update;
  logic               err_ch;
  logic               dump_req  = 1'b0;
  logic               busy;
  logic               m_valid;
  logic [7:0]         m_data;
  logic               m_ready   = 1'b1;

  int checks = 0;
  int errors = 0;

  // Reference model: pending sample sums/counts and published averages per channel.
  int              psum [N_CH];
  int              pn   [N_CH];
  int              mavg [N_CH];
  int              snap [N_CH];
  logic [N_CH-1:0] cur_mask = '0;
  logic [N_CH-1:0] exp_upd;
  logic            exp_err;
  logic [7:0]      got  [$];
  logic [7:0]      expq [$];

  adc_channel_aggregator #(
    .N_CH     (N_CH),
    .DW       (DW),
    .AVG_LOG2 (AVG_LOG2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ch       (s_ch),
    .s_data     (s_data),
    .ch_enable  (ch_enable),
    .avg_bus    (avg_bus),
    .avg_update (avg_update),
    .err_ch     (err_ch),
    .dump_req   (dump_req),
    .busy       (busy),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic void model_clear();
    for (int k = 0; k < N_CH; k++) begin
      psum[k] = 0;
      pn[k]   = 0;
      mavg[k] = 0;
    end
  endfunction

  function automatic logic [N_CH*DW-1:0] model_bus();
    logic [N_CH*DW-1:0] b;
    for (int k = 0; k < N_CH; k++) b[k*DW +: DW] = DW'(mavg[k]);
    return b;
  endfunction

  function automatic void build_expected(input logic [N_CH-1:0] mask);
    logic [7:0] x;
    expq.delete();
    expq.push_back(8'hA5);
    x = 8'hA5;
    for (int k = 0; k < N_CH; k++) begin
      if (mask[k]) begin
        expq.push_back(8'(k));
        expq.push_back(8'(snap[k] / 256));
        expq.push_back(8'(snap[k] % 256));
        x = x ^ 8'(k) ^ 8'(snap[k] / 256) ^ 8'(snap[k] % 256);
      end
    end
    expq.push_back(x);
  endfunction

  task automatic set_mask(input logic [N_CH-1:0] m);
    ch_enable = m;
    cur_mask  = m;
    for (int k = 0; k < N_CH; k++) begin
      if (!m[k]) begin
        psum[k] = 0;
        pn[k]   = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  // Drive one sample for one cycle; afterwards exp_upd/exp_err hold what the DUT should show now.
  task automatic send_sample(input int ch, input int data);
    s_valid = 1'b1;
    s_ch    = CHW'(ch);
    s_data  = DW'(data);
    @(posedge clk); #1;
    s_valid = 1'b0;
    exp_upd = '0;
    exp_err = (ch >= N_CH);
    if (ch < N_CH && cur_mask[ch]) begin
      psum[ch] += data;
      pn[ch]   += 1;
      if (pn[ch] == NAVG) begin
        mavg[ch]    = psum[ch] / NAVG;
        psum[ch]    = 0;
        pn[ch]      = 0;
        exp_upd[ch] = 1'b1;
      end
    end
  endtask

  task automatic start_dump();
    for (int k = 0; k < N_CH; k++) snap[k] = mavg[k];
    build_expected(cur_mask);
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
  endtask

  task automatic collect_frame(input bit rand_ready, input bit poke_dump,
                               output int stall_bad, output bit timed_out);
    logic [7:0] held;
    bit         stalled;
    bit         done;
    got.delete();
    stall_bad = 0;
    stalled   = 1'b0;
    done      = 1'b0;
    held      = '0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      m_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      dump_req = (poke_dump && busy === 1'b1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (stalled && (m_valid !== 1'b1 || m_data !== held)) stall_bad++;
      stalled = (m_valid === 1'b1) && !m_ready;
      held    = m_data;
      if (m_valid === 1'b1 && m_ready) got.push_back(m_data);
      if (busy === 1'b0) done = 1'b1;
      @(posedge clk); #1;
    end
    dump_req  = 1'b0;
    m_ready   = 1'b1;
    timed_out = !done;
  endtask

  task automatic quiet_cycles(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (m_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (avg_bus !== '0 || avg_update !== '0 || err_ch !== 1'b0) begin
      errors++;
      $display("FAIL reset_ingest: avg_bus=%h avg_update=%b err_ch=%b, required all zero",
               avg_bus, avg_update, err_ch);
    end
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_stream: busy=%b m_valid=%b m_data=%h, required 0/0/00", busy, m_valid, m_data);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_clear();
  endtask

  task automatic test_average();
    int vals [4] = '{10, 11, 12, 14};
    set_mask(N_CH'(1) << 3);
    for (int i = 0; i < 4; i++) begin
      send_sample(3, vals[i]);
      checks++;
      if (avg_update !== exp_upd) begin
        errors++;
        $display("FAIL avg_update_seq%0d: avg_update=%b, required %b", i, avg_update, exp_upd);
      end
    end
    checks++;
    if (avg_bus[3*DW +: DW] !== 12'd11) begin
      errors++;
      $display("FAIL avg_ch3: got %0d, required 11", avg_bus[3*DW +: DW]);
    end
    for (int i = 0; i < 4; i++) send_sample(5, 100 + i);
    checks++;
    if (avg_bus[5*DW +: DW] !== 12'd0 || avg_update !== '0) begin
      errors++;
      $display("FAIL disabled_ch5: avg=%0d avg_update=%b, required 0/0", avg_bus[5*DW +: DW], avg_update);
    end
  endtask

  task automatic test_err();
    for (int ch = N_CH; ch < 16; ch += 2) begin
      send_sample(ch, 55);
      checks++;
      if (err_ch !== 1'b1 || avg_bus !== model_bus()) begin
        errors++;
        $display("FAIL err_ch_s%0d: err_ch=%b avg_bus=%h, required 1 and %h", ch, err_ch, avg_bus, model_bus());
      end
      @(posedge clk); #1;
      checks++;
      if (err_ch !== 1'b0) begin
        errors++;
        $display("FAIL err_ch_pulse_s%0d: err_ch=%b one cycle later, required 0", ch, err_ch);
      end
    end
  endtask

  task automatic test_frame();
    int stall_bad;
    bit timed_out;
    int seen;
    set_mask(13'b101);
    for (int i = 0; i < NAVG; i++) send_sample(0, 'h123);
    for (int i = 0; i < NAVG; i++) send_sample(2, 'hFFF);
    checks++;
    if (avg_bus !== model_bus()) begin
      errors++;
      $display("FAIL frame_setup_avg: avg_bus=%h, required %h", avg_bus, model_bus());
    end
    start_dump();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL frame_hdr_latency: m_valid=%b m_data=%h busy=%b, required 1/a5/1", m_valid, m_data, busy);
    end
    collect_frame(1'b0, 1'b0, stall_bad, timed_out);
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL frame_timeout: busy=%b after 400 cycles, required 0", busy);
    end
    checks++;
    if (got.size() != expq.size()) begin
      errors++;
      $display("FAIL frame_len: got %0d bytes, required %0d", got.size(), expq.size());
    end else begin
      foreach (expq[i]) begin
        checks++;
        if (got[i] !== expq[i]) begin
          errors++;
          $display("FAIL frame_byte%0d: got %h, required %h", i, got[i], expq[i]);
        end
      end
    end
    quiet_cycles(5, seen);
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL frame_idle_after: %0d cycles with m_valid/busy high, required 0", seen);
    end
  endtask

  task automatic test_frame_stall();
    int stall_bad;
    bit timed_out;
    start_dump();
    collect_frame(1'b1, 1'b0, stall_bad, timed_out);
    checks++;
    if (timed_out || stall_bad != 0) begin
      errors++;
      $display("FAIL stall_hold: timed_out=%b unstable_stalls=%0d, required 0/0", timed_out, stall_bad);
    end
    checks++;
    if (got.size() != expq.size()) begin
      errors++;
      $display("FAIL stall_len: got %0d bytes, required %0d", got.size(), expq.size());
    end else begin
      foreach (expq[i]) begin
        checks++;
        if (got[i] !== expq[i]) begin
          errors++;
          $display("FAIL stall_byte%0d: got %h, required %h", i, got[i], expq[i]);
        end
      end
    end
  endtask

  task automatic test_snapshot_busy();
    int stall_bad;
    bit timed_out;
    int seen;
    m_ready = 1'b0;
    start_dump();
    for (int i = 0; i < NAVG; i++) send_sample(0, int'($urandom_range(0, 4095)));
    checks++;
    if (avg_bus !== model_bus() || avg_update[0] !== 1'b1) begin
      errors++;
      $display("FAIL live_update_midframe: avg_bus=%h upd=%b, required %h/1", avg_bus, avg_update[0], model_bus());
    end
    collect_frame(1'b1, 1'b1, stall_bad, timed_out);
    checks++;
    if (timed_out || stall_bad != 0) begin
      errors++;
      $display("FAIL snap_hold: timed_out=%b unstable_stalls=%0d, required 0/0", timed_out, stall_bad);
    end
    checks++;
    if (got.size() != expq.size()) begin
      errors++;
      $display("FAIL snap_len: got %0d bytes, required %0d", got.size(), expq.size());
    end else begin
      foreach (expq[i]) begin
        checks++;
        if (got[i] !== expq[i]) begin
          errors++;
          $display("FAIL snap_byte%0d: got %h, required %h", i, got[i], expq[i]);
        end
      end
    end
    quiet_cycles(5, seen);
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL dump_while_busy: %0d active cycles after frame, required 0", seen);
    end
  endtask

  task automatic test_empty_mask();
    int stall_bad;
    bit timed_out;
    set_mask('0);
    start_dump();
    collect_frame(1'b0, 1'b0, stall_bad, timed_out);
    checks++;
    if (timed_out || got.size() != 2 || got[0] !== 8'hA5 || got[1] !== 8'hA5) begin
      errors++;
      $display("FAIL empty_frame: %0d bytes (timed_out=%b), required a5 a5", got.size(), timed_out);
    end
  endtask

  task automatic test_reset_midframe();
    int seen;
    set_mask(13'b101);
    m_ready = 1'b1;
    start_dump();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || avg_bus !== '0 || avg_update !== '0) begin
      errors++;
      $display("FAIL reset_midframe: m_valid=%b busy=%b avg_bus=%h, required 0/0/0", m_valid, busy, avg_bus);
    end
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    quiet_cycles(20, seen);
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_bytes: %0d active cycles after reset, required 0", seen);
    end
  endtask

  task automatic test_random_ingest();
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 15) == 0) begin
        set_mask(N_CH'($urandom | $urandom));
      end else begin
        send_sample(int'($urandom_range(0, 15)), int'($urandom_range(0, 4095)));
        checks++;
        if (avg_update !== exp_upd || err_ch !== exp_err) begin
          errors++;
          $display("FAIL rand_flags_it%0d: upd=%b err=%b, required %b/%b", it, avg_update, err_ch, exp_upd, exp_err);
        end
        checks++;
        if (avg_bus !== model_bus()) begin
          errors++;
          $display("FAIL rand_avg_it%0d: avg_bus=%h, required %h", it, avg_bus, model_bus());
        end
      end
    end
  endtask

  task automatic test_random_frame();
    int stall_bad;
    bit timed_out;
    set_mask(N_CH'($urandom | $urandom));
    start_dump();
    collect_frame(1'b1, 1'b1, stall_bad, timed_out);
    checks++;
    if (timed_out || stall_bad != 0) begin
      errors++;
      $display("FAIL rand_frame_hold: timed_out=%b unstable_stalls=%0d, required 0/0", timed_out, stall_bad);
    end
    checks++;
    if (got.size() != expq.size()) begin
      errors++;
      $display("FAIL rand_frame_len: got %0d bytes, required %0d", got.size(), expq.size());
    end else begin
      foreach (expq[i]) begin
        checks++;
        if (got[i] !== expq[i]) begin
          errors++;
          $display("FAIL rand_frame_byte%0d: got %h, required %h", i, got[i], expq[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_average();
    test_err();
    test_frame();
    test_frame_stall();
    test_snapshot_busy();
    test_empty_mask();
    test_reset_midframe();
    test_random_ingest();
    test_random_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
